// File: rtl/systolic_seq_ctrl_if.sv
// Host result port of systolic_seq_ctrl: valid/ready beat stream with a last marker.
interface systolic_seq_ctrl_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer for an N x N systolic MAC array: operand load, skewed compute, result snapshot
// and serialisation. Define OUT_SAT_EN to emit one signed-saturated OUT_W beat per result.

// Skew decode for one row/column: lane i is live while 0 <= step-i < N.
module systolic_skew_lane #(
  parameter int N     = 2,
  parameter int LANE  = 0,
  parameter int STW   = 3,
  parameter int SEL_W = 1
) (
  input  logic             act_i,
  input  logic [STW-1:0]   step_i,
  output logic             en_o,
  output logic [SEL_W-1:0] sel_o
);
  logic [STW-1:0] off;

  assign off   = step_i - STW'(LANE);
  assign en_o  = act_i && (step_i >= STW'(LANE)) && (off < STW'(N));
  assign sel_o = en_o ? off[SEL_W-1:0] : '0;
endmodule

module systolic_seq_ctrl #(
  parameter  int N     = 2,
  parameter  int ACC_W = 16,
  parameter  int OUT_W = 8,
  localparam int AW    = $clog2(2*N*N),
  localparam int SEL_W = (N < 2) ? 1 : $clog2(N),
  localparam int BYTES = ACC_W / OUT_W,
  localparam int NSTEP = 3*N - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en_i,
  input  logic                   transpose_i,
  input  logic [N*N*ACC_W-1:0]   c_flat_i,
  output logic [AW-1:0]          mem_addr_o,
  output logic                   clear_o,
  output logic                   data_valid_o,
  output logic [N*SEL_W-1:0]     a_sel_o,
  output logic [N*SEL_W-1:0]     b_sel_o,
  output logic [N-1:0]           a_en_o,
  output logic [N-1:0]           b_en_o,
  output logic                   transpose_out_o,
  output logic                   busy_o,
  output logic                   done_o,
  systolic_seq_ctrl_if.master    host
);
`ifdef OUT_SAT_EN
  localparam int BPE = 1;
`else
  localparam int BPE = BYTES;
`endif
  localparam int STW = $clog2(NSTEP + 1);
  localparam int EW  = $clog2(N*N);
  localparam int BCW = (BPE > 1) ? $clog2(BPE) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(2*N*N - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] COMPUTE = 3'd2;
  localparam logic [2:0] SNAP    = 3'd3;
  localparam logic [2:0] OUTPUT  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [STW-1:0] step_q, step_d;
  logic [EW-1:0]  elem_q, elem_d;
  logic [BCW-1:0] byte_q, byte_d;
  logic           done_q, done_d;
  logic           tr_q;
  logic [N*N-1:0][ACC_W-1:0] snap_q;

  logic             in_comp, in_out, beat_last;
  logic [ACC_W-1:0] cur_elem;
  logic [OUT_W-1:0] beat;

  assign in_comp   = (state_q == COMPUTE);
  assign in_out    = (state_q == OUTPUT);
  assign beat_last = (elem_q == EW'(N*N - 1)) && (byte_q == BCW'(BPE - 1));

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    step_d     = step_q;
    elem_d     = elem_q;
    byte_d     = byte_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_en_i) begin
          mem_addr_d = AW'(1);
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (load_en_i) begin
          if (mem_addr_q == LAST_ADDR) begin
            mem_addr_d = '0;
            step_d     = '0;
            state_d    = COMPUTE;
          end else begin
            mem_addr_d = mem_addr_q + AW'(1);
          end
        end
      end
      COMPUTE: begin
        if (step_q == STW'(NSTEP - 1)) begin
          step_d  = '0;
          state_d = SNAP;
        end else begin
          step_d = step_q + STW'(1);
        end
      end
      SNAP: begin
        elem_d  = '0;
        byte_d  = '0;
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (host.out_ready) begin
          if (beat_last) begin
            elem_d  = '0;
            byte_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (byte_q == BCW'(BPE - 1)) begin
            byte_d = '0;
            elem_d = elem_q + EW'(1);
          end else begin
            byte_d = byte_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      step_q     <= '0;
      elem_q     <= '0;
      byte_q     <= '0;
      done_q     <= 1'b0;
      tr_q       <= 1'b0;
      snap_q     <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      step_q     <= step_d;
      elem_q     <= elem_d;
      byte_q     <= byte_d;
      done_q     <= done_d;
      tr_q       <= transpose_i;
      if (state_q == SNAP) snap_q <= c_flat_i;
    end
  end

  // Rows and columns share one skew schedule, so b mirrors a.
  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_skew_lane #(.N(N), .LANE(i), .STW(STW), .SEL_W(SEL_W)) u_skew (
      .act_i (in_comp),
      .step_i(step_q),
      .en_o  (a_en_o[i]),
      .sel_o (a_sel_o[i*SEL_W +: SEL_W])
    );
  end
  assign b_en_o  = a_en_o;
  assign b_sel_o = a_sel_o;

  assign cur_elem = snap_q[elem_q];

`ifdef OUT_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  logic sat_hi, sat_lo;
  assign sat_hi = $signed(cur_elem) > SMAX;
  assign sat_lo = $signed(cur_elem) < SMIN;
  assign beat   = sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                  sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} : cur_elem[OUT_W-1:0];
`else
  logic [BYTES-1:0][OUT_W-1:0] cur_slices;
  assign cur_slices = cur_elem;
  // Most-significant slice leaves first.
  assign beat = cur_slices[BCW'(BYTES - 1) - byte_q];
`endif

  assign mem_addr_o      = mem_addr_q;
  assign clear_o         = in_comp && (step_q == '0);
  assign data_valid_o    = in_comp;
  assign transpose_out_o = tr_q;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;
  assign host.out_valid  = in_out;
  assign host.out_data   = in_out ? beat : '0;
  assign host.out_last   = in_out && beat_last;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed + randomized bench for systolic_seq_ctrl (N=2 and N=4 instances) with a beat-queue model.
module tb_systolic_seq_ctrl;
  localparam int N = 2, N4 = 4, ACC_W = 16, OUT_W = 8, BYTES = ACC_W / OUT_W;
`ifdef OUT_SAT_EN
  localparam int BPE = 1;
`else
  localparam int BPE = BYTES;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, load_en, load_en4, transpose;
  logic [N*N*ACC_W-1:0]   c_flat;
  logic [N4*N4*ACC_W-1:0] c_flat4;
  logic [2:0] mem_addr;
  logic [4:0] mem_addr4;
  logic clear, data_valid, tr_out, busy, done;
  logic clear4, data_valid4, tr_out4, busy4, done4;
  logic [1:0] a_sel, b_sel, a_en, b_en;
  logic [7:0] a_sel4, b_sel4;
  logic [3:0] a_en4, b_en4;

  systolic_seq_ctrl_if #(.OUT_W(OUT_W)) hif ();
  systolic_seq_ctrl_if #(.OUT_W(OUT_W)) hif4 ();

  systolic_seq_ctrl #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .load_en_i(load_en), .transpose_i(transpose), .c_flat_i(c_flat),
    .mem_addr_o(mem_addr), .clear_o(clear), .data_valid_o(data_valid), .a_sel_o(a_sel),
    .b_sel_o(b_sel), .a_en_o(a_en), .b_en_o(b_en), .transpose_out_o(tr_out), .busy_o(busy),
    .done_o(done), .host(hif));

  systolic_seq_ctrl #(.N(N4), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut4 (
    .clk(clk), .rst(rst), .load_en_i(load_en4), .transpose_i(transpose), .c_flat_i(c_flat4),
    .mem_addr_o(mem_addr4), .clear_o(clear4), .data_valid_o(data_valid4), .a_sel_o(a_sel4),
    .b_sel_o(b_sel4), .a_en_o(a_en4), .b_en_o(b_en4), .transpose_out_o(tr_out4), .busy_o(busy4),
    .done_o(done4), .host(hif4));

  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int pat[4] = '{1, 0, 0, 1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic pt, pr;
    pt = transpose;
    pr = rst;
    @(posedge clk); #1;
    chk("transpose_out", 64'(tr_out), pr ? 64'd0 : 64'(pt));
    chk("transpose_out4", 64'(tr_out4), pr ? 64'd0 : 64'(pt));
    transpose = 1'($urandom);
  endtask

  // Beats for one accumulator value: MS slice first, or one saturated beat.
  function automatic void push_elem(input longint unsigned v);
`ifdef OUT_SAT_EN
    longint sv;
    sv = (v >= 64'd32768) ? longint'(v) - 65536 : longint'(v);
    if (sv > 127) sv = 127;
    if (sv < -128) sv = -128;
    exp_q.push_back(8'(sv));
`else
    for (int b = BYTES - 1; b >= 0; b--) exp_q.push_back(8'((v >> (8*b)) & 255));
`endif
  endfunction

  function automatic void build_exp2();
    exp_q.delete();
    for (int e = 0; e < N*N; e++) push_elem(longint'(c_flat[e*ACC_W +: ACC_W]));
  endfunction

  // Full N=2 tile: gap=1 randomises load_en; rmode 0 ready=1, 1 pattern 1,0,0,1, 2 random.
  task automatic run_tile2(input int gap, input int rmode);
    int loaded, idx, g;
    logic [1:0] een;
    logic [1:0] esel;
    build_exp2();
    loaded = 0; g = 0;
    while (loaded < 2*N*N && g < 500) begin
      load_en = gap ? 1'($urandom) : 1'b1;
      if (load_en) loaded++;
      tick(); g++;
      chk("load_mem_addr", 64'(mem_addr), 64'(loaded % (2*N*N)));
      chk("load_busy", 64'(busy), 64'(loaded > 0));
    end
    load_en = 1'b0;
    for (int s = 0; s < 3*N - 2; s++) begin
      een = '0; esel = '0;
      for (int i = 0; i < N; i++)
        if (s - i >= 0 && s - i < N) begin een[i] = 1'b1; esel[i] = 1'(s - i); end
      chk("comp_data_valid", 64'(data_valid), 64'd1);
      chk("comp_clear", 64'(clear), 64'(s == 0));
      chk("comp_a_en", 64'(a_en), 64'(een));
      chk("comp_a_sel", 64'(a_sel), 64'(esel));
      chk("comp_b_en", 64'(b_en), 64'(een));
      chk("comp_b_sel", 64'(b_sel), 64'(esel));
      chk("comp_out_valid", 64'(hif.out_valid), 64'd0);
      load_en = 1'($urandom);
      tick();
      chk("comp_mem_addr", 64'(mem_addr), 64'd0);
      load_en = 1'b0;
    end
    chk("snap_data_valid", 64'(data_valid), 64'd0);
    chk("snap_out_valid", 64'(hif.out_valid), 64'd0);
    chk("snap_busy", 64'(busy), 64'd1);
    tick();
    c_flat = {$urandom, $urandom};
    idx = 0; g = 0;
    while (idx < exp_q.size() && g < 200) begin
      hif.out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(pat[g % 4]) : 1'($urandom);
      load_en = 1'($urandom);
      chk("out_valid", 64'(hif.out_valid), 64'd1);
      chk("out_data", 64'(hif.out_data), 64'(exp_q[idx]));
      chk("out_last", 64'(hif.out_last), 64'(idx == exp_q.size() - 1));
      chk("out_done_low", 64'(done), 64'd0);
      tick(); g++;
      chk("out_mem_addr", 64'(mem_addr), 64'd0);
      if (hif.out_ready) idx++;
    end
    load_en = 1'b0;
    hif.out_ready = 1'b0;
    chk("out_timeout", 64'(g < 200), 64'd1);
    chk("done_pulse", 64'(done), 64'd1);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_out_valid", 64'(hif.out_valid), 64'd0);
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    int loaded, cnt, idx, g;
    rst = 1'b1; load_en = 1'b0; load_en4 = 1'b0; transpose = 1'b0;
    c_flat = '0; c_flat4 = '0; hif.out_ready = 1'b0; hif4.out_ready = 1'b0;
    tick(); tick();
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outs", 64'({clear, data_valid, a_en, a_sel, b_en, b_sel, done}), 64'd0);
    chk("rst_host", 64'({hif.out_valid, hif.out_last, hif.out_data}), 64'd0);
    rst = 1'b0;
    tick();

    // Reset mid-LOAD aborts the tile.
    load_en = 1'b1;
    repeat (5) tick();
    chk("midload_addr", 64'(mem_addr), 64'd5);
    load_en = 1'b0; rst = 1'b1;
    tick();
    chk("abort_mem_addr", 64'(mem_addr), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_outs", 64'({clear, data_valid, a_en, a_sel, done, hif.out_valid, hif.out_data}), 64'd0);
    rst = 1'b0;
    tick();
    chk("abort_no_done", 64'(done), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);

    c_flat = {16'h0005, 16'h7FFF, 16'hFF80, 16'h0123};
    run_tile2(0, 0);
    c_flat = {16'h0005, 16'h7FFF, 16'hFF80, 16'h0123};
    run_tile2(0, 1);
    repeat (3) begin
      c_flat = {$urandom, $urandom};
      run_tile2(1, 2);
    end

    // N=4: gapped load, 10-cycle compute, full tile drained with load_en noise.
    for (int e = 0; e < N4*N4; e++) c_flat4[e*ACC_W +: ACC_W] = 16'($urandom);
    exp_q.delete();
    for (int e = 0; e < N4*N4; e++) push_elem(longint'(c_flat4[e*ACC_W +: ACC_W]));
    loaded = 0;
    for (int k = 0; loaded < 2*N4*N4 && k < 200; k++) begin
      load_en4 = (k % 2 == 0);
      if (load_en4) loaded++;
      tick();
      chk("n4_mem_addr", 64'(mem_addr4), 64'(loaded % (2*N4*N4)));
    end
    load_en4 = 1'b0;
    cnt = 0;
    while (data_valid4 && cnt < 40) begin
      chk("n4_clear", 64'(clear4), 64'(cnt == 0));
      cnt++;
      tick();
    end
    chk("n4_compute_len", 64'(cnt), 64'd10);
    tick();
    idx = 0; g = 0;
    hif4.out_ready = 1'b1;
    while (idx < exp_q.size() && g < 200) begin
      load_en4 = 1'($urandom);
      chk("n4_out_valid", 64'(hif4.out_valid), 64'd1);
      chk("n4_out_data", 64'(hif4.out_data), 64'(exp_q[idx]));
      chk("n4_out_last", 64'(hif4.out_last), 64'(idx == exp_q.size() - 1));
      tick(); g++; idx++;
      chk("n4_out_mem_addr", 64'(mem_addr4), 64'd0);
    end
    load_en4 = 1'b0;
    hif4.out_ready = 1'b0;
    chk("n4_beats", 64'(idx), 64'(N4*N4*BPE));
    chk("n4_done", 64'(done4), 64'd1);
    chk("n4_end_valid", 64'(hif4.out_valid), 64'd0);
    chk("n4_end_busy", 64'(busy4), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Parametrised controller for an N x N weight-stationary-free systolic MAC array.
- Sequences the tile load from operand memory and generates skewed per-row/per-column operand selects and the clear/data_valid strobes.
- Snapshots the N*N accumulator results and byte-serialises them to the host over a valid/ready port.
- Sits between the operand memory, the systolic array and the host output interface; successor to the fixed 2x2 controller.

Parameters:
- N, 2, array dimension (rows = columns); legal 2..8.
- ACC_W, 16, accumulator width per PE; must be a multiple of OUT_W.
- OUT_W, 8, host output beat width.
- Derived, not overridable:
  - AW = $clog2(2*N*N)
  - SEL_W = max(1, $clog2(N))
  - BYTES = ACC_W/OUT_W
  - NSTEP = 3N-2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- load_en  in  1  one operand word written to memory this cycle
- transpose  in  1  input-matrix transpose request; registered to transpose_out
- c_flat  in  N*N*ACC_W  array results, element (r,c) at bits [(r*N+c)*ACC_W +: ACC_W]
- mem_addr  out  AW  operand memory write address
- clear  out  1  PEs overwrite rather than accumulate this cycle
- data_valid  out  1  array operands valid this cycle
- a_sel  out  N*SEL_W  row i weight select at [i*SEL_W +: SEL_W]
- b_sel  out  N*SEL_W  column j input select
- a_en  out  N  row i operand valid mask
- b_en  out  N  column j operand valid mask
- transpose_out  out  1  registered transpose
- out_data  out  OUT_W  result beat
- out_valid  out  1  out_data valid
- out_ready  in  1  host accepts beat
- out_last  out  1  final beat of tile
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, final beat accepted

Behaviour:
- Reset values:
  - state=IDLE.
  - All outputs 0, including out_data, selects, masks, counters and the snapshot buffer.
  - Reset mid-operation aborts the tile immediately; no done pulse.
- States: IDLE, LOAD, COMPUTE, SNAP, OUTPUT.
- IDLE:
  - mem_addr held 0.
  - load_en -> mem_addr<=1, go to LOAD.
- LOAD:
  - Each load_en increments mem_addr.
  - On the 2N^2-th beat (mem_addr == 2N^2-1 with load_en): mem_addr<=0, go to COMPUTE.
  - Cycles without load_en stall; no timeout.
- COMPUTE:
  - step counter runs 0..NSTEP-1, one step per cycle.
  - data_valid=1 throughout; clear=1 only at step 0.
  - Row i: a_en[i]=1 and a_sel[i]=step-i when 0<=step-i<N; otherwise a_en[i]=0 and a_sel[i]=0. Columns use the identical rule on b.
  - Selects and masks are combinational from step.
  - At step NSTEP-1 go to SNAP.
- SNAP:
  - One cycle; data_valid=0.
  - Registers c_flat into the snapshot buffer at the end of the cycle.
  - Beat index <= 0; go to OUTPUT.
- OUTPUT:
  - out_valid=1.
  - Beat order: row-major elements; within an element, most-significant OUT_W slice first.
  - Total beats N*N*BYTES.
  - out_data and out_last are stable while out_valid && !out_ready.
  - Index advances only on out_valid && out_ready.
  - out_last=1 on the final beat; its acceptance pulses done, sends state to IDLE and drops out_valid.
- load_en outside IDLE/LOAD: ignored; mem_addr unchanged.
- transpose_out <= transpose every cycle, independent of state.
- Latency from the last load beat to the first out_valid: NSTEP+1 cycles.

Optional Feature:
- Macro: OUT_SAT_EN.
- Defined:
  - Each result is emitted as one OUT_W beat: signed saturation of the ACC_W value to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Tile length N*N beats.
- Undefined:
  - Full-width byte serialisation as above, N*N*BYTES beats.
  - No saturation logic is instantiated.

Test Plan:
- N=2, rst during LOAD at mem_addr=5 -> next cycle state IDLE, mem_addr=0, busy=0, all outputs 0; done never pulses.
- N=2, 8 consecutive load_en beats -> mem_addr 1..7 then 0; COMPUTE lasts exactly 4 cycles with clear only in the first. Per step, a_en/a_sel:
  - step0: 01, a_sel={x,0}
  - step1: 11, a_sel={0,1}
  - step2: 10, a_sel={1,x}
  - step3: 00
- N=2, c_flat holds c00=0x0123, c01=0xFF80, c10=0x7FFF, c11=0x0005, out_ready=1 -> beats 01,23,FF,80,7F,FF,00,05; out_last on the 8th; done one cycle later-edge aligned with acceptance; first out_valid 5 cycles after last load.
- Same data, out_ready toggled 1,0,0,1,... -> identical beat sequence; out_data held during stalls; no beat lost or duplicated.
- OUT_SAT_EN defined, same data -> beats 7F,80,7F,05, out_last on the 4th.
- N=4, load_en gapped every other cycle for 32 beats -> COMPUTE 10 cycles, 32 output beats; load_en pulses during OUTPUT leave mem_addr at 0.
